screen_flow_controller: RTL

Top-level game-flow sequencer that sits directly downstream of the main game screen. It consumes that screen's `RGB_screen_main`, `life` and `score` outputs together with the start-screen and game-over-screen pixel streams. It selects which screen drives the VGA pixel path, and it holds the main screen in reset while that screen is not active. It latches the final score at game over and, optionally, tracks a session high score.

---
 rtl/screen_flow_controller_if.sv | 29 ++
 rtl/screen_flow_controller.sv | 102 ++++++++++
 2 files changed

// File: rtl/screen_flow_controller_if.sv
// Signal bundle between the game-flow sequencer and its surrounding screens/VGA path.
// The controller takes the slave side; the top-level glue (or a bench) takes the master side.
interface screen_flow_controller_if;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic [3:0] life;
    logic [3:0] score;
    logic [7:0] RGB_screen_start;
    logic [7:0] RGB_screen_main;
    logic [7:0] RGB_screen_over;
    logic [7:0] RGB_out;
    logic       main_resetN;
    logic [1:0] flow_state;
    logic [3:0] final_score;
    logic [3:0] high_score;
    logic       new_record;

    modport master (
        output startOfFrame, key5IsPressed, life, score,
               RGB_screen_start, RGB_screen_main, RGB_screen_over,
        input  RGB_out, main_resetN, flow_state, final_score, high_score, new_record
    );

    modport slave (
        input  startOfFrame, key5IsPressed, life, score,
               RGB_screen_start, RGB_screen_main, RGB_screen_over,
        output RGB_out, main_resetN, flow_state, final_score, high_score, new_record
    );
endinterface

// File: rtl/screen_flow_controller.sv
// START/PLAY/HOLD/OVER game-flow sequencer: screen select, main-screen reset, score latch.
// Define SCREEN_FLOW_HIGH_SCORE_EN to build the session high-score tracker.
module screen_flow_controller #(
    parameter int HOLD_FRAMES     = 60,
    parameter int MIN_OVER_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    screen_flow_controller_if.slave    bus
);
    typedef enum logic [1:0] {
        START = 2'b00,
        PLAY  = 2'b01,
        HOLD  = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] OVER_MIN  = 8'(MIN_OVER_FRAMES);

    state_t     state, state_nxt;
    logic       key5_d;
    logic       key5_rise;
    logic [7:0] frame_cnt;
    logic       latch_score;
    logic [7:0] rgb_q;
    logic [3:0] final_q;

    assign key5_rise = bus.key5IsPressed & ~key5_d;

    always_comb begin
        state_nxt   = state;
        latch_score = 1'b0;
        case (state)
            START: if (key5_rise) state_nxt = PLAY;
            // frame_cnt==0 marks the first frame, when life is not yet valid
            PLAY:  if (bus.startOfFrame && frame_cnt >= 8'd1 && bus.life == 4'd0) begin
                       state_nxt   = HOLD;
                       latch_score = 1'b1;
                   end
            HOLD:  if (bus.startOfFrame && frame_cnt == HOLD_LAST) state_nxt = OVER;
            OVER:  if (key5_rise && frame_cnt >= OVER_MIN) state_nxt = START;
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= START;
            key5_d    <= 1'b0;
            frame_cnt <= 8'd0;
            final_q   <= 4'd0;
            rgb_q     <= 8'd0;
        end else begin
            state  <= state_nxt;
            key5_d <= bus.key5IsPressed;
            if (state_nxt != state)
                frame_cnt <= 8'd0;
            else if (bus.startOfFrame && frame_cnt != 8'hFF)
                frame_cnt <= frame_cnt + 8'd1;
            if (latch_score)
                final_q <= bus.score;
            case (state)
                START:   rgb_q <= bus.RGB_screen_start;
                OVER:    rgb_q <= bus.RGB_screen_over;
                default: rgb_q <= bus.RGB_screen_main;
            endcase
        end
    end

`ifdef SCREEN_FLOW_HIGH_SCORE_EN
    logic [3:0] high_q;
    logic       record_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_q   <= 4'd0;
            record_q <= 1'b0;
        end else if (latch_score) begin
            if (bus.score > high_q) begin
                high_q   <= bus.score;
                record_q <= 1'b1;
            end else begin
                record_q <= 1'b0;
            end
        end else if (state == OVER && state_nxt == START) begin
            record_q <= 1'b0;
        end
    end

    assign bus.high_score = high_q;
    assign bus.new_record = record_q;
`else
    assign bus.high_score = 4'd0;
    assign bus.new_record = 1'b0;
`endif

    assign bus.RGB_out     = rgb_q;
    assign bus.final_score = final_q;
    assign bus.flow_state  = state;
    assign bus.main_resetN = (state == PLAY) || (state == HOLD);
endmodule
